// File: rtl/fetch_sequencer_if.sv
// Fetch front-end bus bundle.
//   master : the fetch sequencer (drives the memory request and the decode packet)
//   slave  : the environment (instruction memory, branch predictor, commit, decode)
// Signals:
//   InstMem_Read/inst_address  -> request to instruction memory
//   InstMem_Ready/inst1_in/inst2_in <- memory response (same-cycle allowed)
//   Pre_Inst1_Branch/Pre_Inst2_Branch/Pre_PC <- predictor hints
//   Flush/Flush_PC             <- commit-time redirect
//   Fetch_Ready                <- decode accepts packet
//   Fetch_* outputs            -> packet to decode
//   Mem_Timeout                -> sticky memory timeout flag
interface fetch_sequencer_if #(parameter int data_lentgh = 32);
  logic                   InstMem_Read;
  logic [data_lentgh-1:0] inst_address;
  logic                   InstMem_Ready;
  logic [data_lentgh-1:0] inst1_in;
  logic [data_lentgh-1:0] inst2_in;
  logic                   Pre_Inst1_Branch;
  logic                   Pre_Inst2_Branch;
  logic [data_lentgh-1:0] Pre_PC;
  logic                   Flush;
  logic [data_lentgh-1:0] Flush_PC;
  logic                   Fetch_Ready;
  logic                   Fetch_Valid1;
  logic                   Fetch_Valid2;
  logic [data_lentgh-1:0] Fetch_PC1;
  logic [data_lentgh-1:0] Fetch_Inst1;
  logic [data_lentgh-1:0] Fetch_Inst2;
  logic                   Fetch_Pred_Taken;
  logic [data_lentgh-1:0] Fetch_Pred_Target;
  logic                   Mem_Timeout;

  modport master (
    output InstMem_Read, inst_address,
    input  InstMem_Ready, inst1_in, inst2_in,
    input  Pre_Inst1_Branch, Pre_Inst2_Branch, Pre_PC,
    input  Flush, Flush_PC, Fetch_Ready,
    output Fetch_Valid1, Fetch_Valid2, Fetch_PC1, Fetch_Inst1, Fetch_Inst2,
    output Fetch_Pred_Taken, Fetch_Pred_Target, Mem_Timeout
  );

  modport slave (
    input  InstMem_Read, inst_address,
    output InstMem_Ready, inst1_in, inst2_in,
    output Pre_Inst1_Branch, Pre_Inst2_Branch, Pre_PC,
    output Flush, Flush_PC, Fetch_Ready,
    input  Fetch_Valid1, Fetch_Valid2, Fetch_PC1, Fetch_Inst1, Fetch_Inst2,
    input  Fetch_Pred_Taken, Fetch_Pred_Target, Mem_Timeout
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues one dual-instruction fetch per memory handshake,
// applies branch-predictor hints to pick the next PC, holds the packet under
// decode backpressure and redirects on flush.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fetch_sequencer_if.master (memory, predictor, flush, decode packet)
//
// state    | meaning
// IDLE     | one cycle after reset, no request
// FETCH    | request outstanding at pc, capture when memory ready and output free
// HOLD     | memory answered but packet register busy; wait for decode
// REDIRECT | one bubble after flush before fetching the new pc
module fetch_sequencer #(
  parameter int                     data_lentgh = 32,
  parameter logic [data_lentgh-1:0] RESET_PC    = '0,
  parameter int                     MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, REDIRECT} state_t;

  localparam logic [3:0] TO_LIMIT = 4'(MEM_TIMEOUT);

  state_t                 state;
  logic [data_lentgh-1:0] pc;
  logic [3:0]             wait_cnt;
  logic                   timeout;
  logic                   mem_read;
  logic                   valid1, valid2, pred_taken;
  logic [data_lentgh-1:0] pc1, inst1, inst2, pred_target;
  logic                   reg_free;

  // Packet register can take new data if empty or being drained this edge.
  assign reg_free = !valid1 || bus.Fetch_Ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      wait_cnt    <= '0;
      timeout     <= 1'b0;
      mem_read    <= 1'b0;
      valid1      <= 1'b0;
      valid2      <= 1'b0;
      pred_taken  <= 1'b0;
      pc1         <= '0;
      inst1       <= '0;
      inst2       <= '0;
      pred_target <= '0;
    end else if (bus.Flush) begin
      state      <= REDIRECT;
      pc         <= {bus.Flush_PC[data_lentgh-1:2], 2'b00};
      valid1     <= 1'b0;
      valid2     <= 1'b0;
      pred_taken <= 1'b0;
      wait_cnt   <= '0;
      mem_read   <= 1'b0;
    end else begin
      // Transfer without a new capture empties the register; a capture below overrides.
      if (valid1 && bus.Fetch_Ready) begin
        valid1 <= 1'b0;
        valid2 <= 1'b0;
      end
      case (state)
        IDLE, REDIRECT: begin
          state    <= FETCH;
          mem_read <= 1'b1;
        end
        FETCH: begin
          if (bus.InstMem_Ready) begin
            if (reg_free) begin
              pc1      <= pc;
              inst1    <= bus.inst1_in;
              inst2    <= bus.inst2_in;
              valid1   <= 1'b1;
              wait_cnt <= '0;
              if (bus.Pre_Inst1_Branch) begin
                valid2      <= 1'b1;
                pred_taken  <= 1'b1;
                pred_target <= bus.Pre_PC;
                pc          <= {bus.Pre_PC[data_lentgh-1:2], 2'b00};
              end else if (bus.Pre_Inst2_Branch) begin
                // Slot2 branch is refetched as slot1 so its prediction applies.
                valid2     <= 1'b0;
                pred_taken <= 1'b0;
                pc         <= pc + data_lentgh'(4);
              end else begin
                valid2     <= 1'b1;
                pred_taken <= 1'b0;
                pc         <= pc + data_lentgh'(8);
              end
            end else begin
              state    <= HOLD;
              mem_read <= 1'b0;
            end
          end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_cnt + 4'd1 >= TO_LIMIT) timeout <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.Fetch_Ready) begin
            state    <= FETCH;
            mem_read <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InstMem_Read      = mem_read;
  assign bus.inst_address      = pc;
  assign bus.Fetch_Valid1      = valid1;
  assign bus.Fetch_Valid2      = valid2;
  assign bus.Fetch_PC1         = pc1;
  assign bus.Fetch_Inst1       = inst1;
  assign bus.Fetch_Inst2       = inst2;
  assign bus.Fetch_Pred_Taken  = pred_taken;
  assign bus.Fetch_Pred_Target = pred_target;
  assign bus.Mem_Timeout       = timeout;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Memory returns addr^K for slot1 and
// (addr+4)^K for slot2 combinationally; inputs change 1ns after each rising edge.
module tb_fetch_sequencer;
  localparam logic [31:0] K = 32'h1357_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.inst1_in = bus.inst_address ^ K;
  assign bus.inst2_in = (bus.inst_address + 32'd4) ^ K;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input logic [31:0] pc1, input logic v2,
                         input logic pt, input logic [31:0] addr);
    chk({tag, "_v1"},   32'(bus.Fetch_Valid1), 32'd1);
    chk({tag, "_v2"},   32'(bus.Fetch_Valid2), 32'(v2));
    chk({tag, "_pc1"},  bus.Fetch_PC1, pc1);
    chk({tag, "_i1"},   bus.Fetch_Inst1, pc1 ^ K);
    chk({tag, "_i2"},   bus.Fetch_Inst2, (pc1 + 32'd4) ^ K);
    chk({tag, "_pt"},   32'(bus.Fetch_Pred_Taken), 32'(pt));
    chk({tag, "_addr"}, bus.inst_address, addr);
  endtask

  initial begin
    bus.InstMem_Ready    = 1'b1;
    bus.Pre_Inst1_Branch = 1'b0;
    bus.Pre_Inst2_Branch = 1'b0;
    bus.Pre_PC           = '0;
    bus.Flush            = 1'b0;
    bus.Flush_PC         = '0;
    bus.Fetch_Ready      = 1'b1;

    // reset
    tick();
    chk("rst_read", 32'(bus.InstMem_Read), 32'd0);
    chk("rst_v1",   32'(bus.Fetch_Valid1), 32'd0);
    chk("rst_v2",   32'(bus.Fetch_Valid2), 32'd0);
    chk("rst_addr", bus.inst_address, 32'h0);
    chk("rst_to",   32'(bus.Mem_Timeout), 32'd0);
    rst = 1'b0;

    // sequential fetch
    tick();
    chk("idle_read", 32'(bus.InstMem_Read), 32'd1);
    chk("idle_addr", bus.inst_address, 32'h0);
    chk("idle_v1",   32'(bus.Fetch_Valid1), 32'd0);
    tick(); chk_pkt("seq0", 32'h0,  1'b1, 1'b0, 32'h8);
    tick(); chk_pkt("seq1", 32'h8,  1'b1, 1'b0, 32'h10);
    tick(); chk_pkt("seq2", 32'h10, 1'b1, 1'b0, 32'h18);

    // slot1 predicted taken at 0x40
    bus.Flush = 1'b1; bus.Flush_PC = 32'h40;
    tick();
    chk("fl40_v1",   32'(bus.Fetch_Valid1), 32'd0);
    chk("fl40_read", 32'(bus.InstMem_Read), 32'd0);
    chk("fl40_addr", bus.inst_address, 32'h40);
    bus.Flush = 1'b0;
    tick();
    chk("rd40_read", 32'(bus.InstMem_Read), 32'd1);
    bus.Pre_Inst1_Branch = 1'b1; bus.Pre_PC = 32'h200;
    tick();
    chk_pkt("s1", 32'h40, 1'b1, 1'b1, 32'h200);
    chk("s1_tgt", bus.Fetch_Pred_Target, 32'h200);
    bus.Pre_Inst1_Branch = 1'b0;
    tick(); chk_pkt("s1n", 32'h200, 1'b1, 1'b0, 32'h208);

    // slot2 predicted taken at 0x80, then both hints at 0x84
    bus.Flush = 1'b1; bus.Flush_PC = 32'h80;
    tick();
    bus.Flush = 1'b0;
    tick();
    chk("rd80_addr", bus.inst_address, 32'h80);
    bus.Pre_Inst2_Branch = 1'b1; bus.Pre_PC = 32'h300;
    tick(); chk_pkt("s2", 32'h80, 1'b0, 1'b0, 32'h84);
    bus.Pre_Inst1_Branch = 1'b1; bus.Pre_PC = 32'h301;
    tick();
    chk_pkt("both", 32'h84, 1'b1, 1'b1, 32'h300);
    chk("both_tgt", bus.Fetch_Pred_Target, 32'h301);
    bus.Pre_Inst1_Branch = 1'b0; bus.Pre_Inst2_Branch = 1'b0;

    // backpressure for 3 cycles
    bus.Fetch_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pkt("hold", 32'h84, 1'b1, 1'b1, 32'h300);
      chk("hold_read", 32'(bus.InstMem_Read), 32'd0);
    end
    bus.Fetch_Ready = 1'b1;
    tick();
    chk("rel_v1",   32'(bus.Fetch_Valid1), 32'd0);
    chk("rel_read", 32'(bus.InstMem_Read), 32'd1);
    chk("rel_addr", bus.inst_address, 32'h300);
    tick(); chk_pkt("rel_pkt", 32'h300, 1'b1, 1'b0, 32'h308);

    // flush during memory wait
    bus.InstMem_Ready = 1'b0;
    tick();
    chk("wt_v1",   32'(bus.Fetch_Valid1), 32'd0);
    chk("wt_addr", bus.inst_address, 32'h308);
    bus.Flush = 1'b1; bus.Flush_PC = 32'h1003;
    tick();
    chk("flw_read", 32'(bus.InstMem_Read), 32'd0);
    chk("flw_addr", bus.inst_address, 32'h1000);
    bus.Flush = 1'b0;
    tick();
    chk("flw_read2", 32'(bus.InstMem_Read), 32'd1);
    chk("flw_addr2", bus.inst_address, 32'h1000);

    // timeout: 15 waiting edges in FETCH
    for (int i = 0; i < 14; i++) tick();
    chk("to_14", 32'(bus.Mem_Timeout), 32'd0);
    tick();
    chk("to_15", 32'(bus.Mem_Timeout), 32'd1);
    bus.InstMem_Ready = 1'b1;
    tick();
    chk_pkt("to_cap", 32'h1000, 1'b1, 1'b0, 32'h1008);
    chk("to_sticky", 32'(bus.Mem_Timeout), 32'd1);

    // address wrap
    bus.Flush = 1'b1; bus.Flush_PC = 32'hFFFF_FFF8;
    tick();
    bus.Flush = 1'b0;
    tick();
    tick(); chk_pkt("wrap", 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0);

    // flush beats capture
    bus.Flush = 1'b1; bus.Flush_PC = 32'h500;
    tick();
    chk("flc_v1",   32'(bus.Fetch_Valid1), 32'd0);
    chk("flc_addr", bus.inst_address, 32'h500);
    chk("flc_to",   32'(bus.Mem_Timeout), 32'd1);

    // reset beats flush, clears timeout
    rst = 1'b1;
    tick();
    chk("rst2_read", 32'(bus.InstMem_Read), 32'd0);
    chk("rst2_addr", bus.inst_address, 32'h0);
    chk("rst2_to",   32'(bus.Mem_Timeout), 32'd0);
    rst = 1'b0; bus.Flush = 1'b0;
    tick();
    chk("rst2_fetch", 32'(bus.InstMem_Read), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end controller that sequences the dual-issue instruction memory port and folds in branch-predictor hints to produce the next fetch PC.
- Sits between the instruction memory / Branch_predictor and the decode stage of Processor.
- Issues one 2-instruction fetch packet per accepted memory handshake.
- Holds the packet under decode backpressure and redirects on commit-time mispredict flush.

Parameters:
- data_lentgh, 32, instruction/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- MEM_TIMEOUT, 15, consecutive wait cycles in FETCH before Mem_Timeout sets (4-bit counter; 1..15 legal)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- InstMem_Read  out  1  fetch request to instruction memory
- inst_address  out  32  fetch address; word aligned, bits[1:0]=00
- InstMem_Ready  in  1  memory returns inst1_in/inst2_in this cycle (same-cycle response allowed)
- inst1_in  in  32  instruction at inst_address
- inst2_in  in  32  instruction at inst_address+4
- Pre_Inst1_Branch  in  1  predictor: slot1 predicted taken
- Pre_Inst2_Branch  in  1  predictor: slot2 predicted taken
- Pre_PC  in  32  predicted target for slot1
- Flush  in  1  mispredict/recovery from commit
- Flush_PC  in  32  restart address
- Fetch_Ready  in  1  decode accepts packet
- Fetch_Valid1  out  1  slot1 valid
- Fetch_Valid2  out  1  slot2 valid
- Fetch_PC1  out  32  PC of slot1; slot2 PC = Fetch_PC1+4
- Fetch_Inst1  out  32  slot1 instruction
- Fetch_Inst2  out  32  slot2 instruction
- Fetch_Pred_Taken  out  1  slot1 carried a taken prediction
- Fetch_Pred_Target  out  32  predicted target (valid when Fetch_Pred_Taken)
- Mem_Timeout  out  1  sticky error flag

Behaviour:
- States: IDLE, FETCH, HOLD, REDIRECT.
- Reset (rst=1 at clk edge):
  - State <= IDLE; PC <= RESET_PC; wait counter <= 0; Mem_Timeout <= 0.
  - All Fetch_* outputs <= 0.
  - InstMem_Read = 0 while in IDLE.
  - Reset mid-operation discards the held packet and any pending request.
- IDLE: one cycle, no request, then FETCH.
- FETCH:
  - InstMem_Read=1, inst_address=PC.
  - Capture occurs at the edge where InstMem_Ready=1 and the output register is free (Fetch_Valid1=0, or Fetch_Ready=1 this cycle).
  - On capture: Fetch_PC1<=PC; Fetch_Inst1<=inst1_in; Fetch_Inst2<=inst2_in; Fetch_Valid1<=1; wait counter<=0.
  - Slot/next-PC rules, evaluated in order:
    1. Pre_Inst1_Branch=1: Valid2<=1 (delay slot); Pred_Taken<=1; Pred_Target<=Pre_PC; next PC<=Pre_PC[31:2],00.
    2. Else Pre_Inst2_Branch=1: Valid2<=0; Pred_Taken<=0; next PC<=PC+4. The branch is refetched as slot1 so Pre_PC applies to it.
    3. Else: Valid2<=1; Pred_Taken<=0; next PC<=PC+8.
  - InstMem_Ready=1 but register not free: no capture; InstMem_Read drops; go to HOLD.
  - InstMem_Ready=0: increment wait counter, saturating. When it reaches MEM_TIMEOUT, Mem_Timeout<=1 (sticky until rst); fetching continues.
- HOLD:
  - InstMem_Read=0; outputs stable.
  - Fetch_Ready=1 clears Fetch_Valid1/2 at the edge, then FETCH.
- Handshake:
  - A packet transfers at an edge with Fetch_Valid1=1 and Fetch_Ready=1.
  - If no new capture happens at that same edge, Fetch_Valid1/2 <= 0.
  - Back-to-back transfers are allowed: FETCH capture plus transfer in one edge gives one packet per cycle.
- Flush:
  - Highest priority, any state except reset.
  - PC <= {Flush_PC[31:2],2'b00}; Fetch_Valid1/2, Pred_Taken <= 0; wait counter <= 0; state <= REDIRECT.
  - A memory response in the Flush cycle is discarded.
- REDIRECT: one bubble cycle, InstMem_Read=0, then FETCH at the new PC.
- Arithmetic: PC+4 and PC+8 are modulo 2^32; wrap from 32'hFFFF_FFF8 to 0 is legal.
- Simultaneous events:
  - Flush beats capture and transfer.
  - rst beats Flush.
  - Pre_Inst1_Branch beats Pre_Inst2_Branch.

Test Plan:
- Sequential fetch: rst 1 cycle, memory always Ready, no predictions, Fetch_Ready=1 -> inst_address 0,8,16,24 on consecutive cycles from the 2nd cycle after reset; Valid1=Valid2=1 every cycle.
- Slot1 predicted taken: at PC=0x40 drive Pre_Inst1_Branch=1, Pre_PC=0x200 -> packet PC1=0x40, Valid2=1, Pred_Taken=1, Pred_Target=0x200; next inst_address=0x200.
- Slot2 predicted taken: at PC=0x80 drive Pre_Inst2_Branch=1 -> packet Valid1=1, Valid2=0; next inst_address=0x84.
- Backpressure: Fetch_Ready=0 for 3 cycles after a capture -> outputs frozen, InstMem_Read=0 during HOLD; on Fetch_Ready=1, the next address is fetched the following cycle with no packet lost or duplicated.
- Flush during memory wait: InstMem_Ready=0, assert Flush with Flush_PC=0x1003 -> Valid cleared, one cycle with InstMem_Read=0, then inst_address=0x1000.
- Timeout: InstMem_Ready held 0 for 15 cycles in FETCH -> Mem_Timeout=1 after the 15th edge and stays 1 after Ready returns; clears only on rst.
